transpose_rd_buf: RTL and testbench
===================================

// Module: transpose_rd_buf
// PURPOSE
//  Ping-pong transpose buffer for the IDCT datapath, opposite direction to the write-side transpose:
//  samples are written in raster order and read back in transposed order.
//  Sits between the row-pass output stream and the column-pass input; carries the per-block size tag.
//  Valid/ready on both sides; sustains 1 sample/cycle when the sink never stalls.
// PARAMETERS
//  WIDTH_X   16   sample width in bits
// PORTS
//  clk        in   1        clock; all state on rising edge
//  rst_n      in   1        reset, asynchronous, active-low
//  in_mode    in   2        block tag: 2'b00 idle, 2'b01 four 4x4 blocks, 2'b10 one 8x8 block, 2'b11 = 8x8
//  in_valid   in   1        d_in/in_mode valid
//  in_ready   out  1        buffer accepts a beat this cycle
//  d_in       in   WIDTH_X  raster-order sample
//  out_valid  out  1        d_out valid
//  out_ready  in   1        sink accepts d_out
//  d_out      out  WIDTH_X  transposed sample (registered)
//  out_mode   out  2        tag of the block currently on d_out
//  out_last   out  1        high with the 64th word of a block
// BEHAVIOUR
//  - Reset: out_valid=0, d_out=0, out_mode=0, out_last=0, both bank-full flags=0, wr/rd bank ptr=0, counters=0.
//    Memory contents are not reset; reset mid-block discards all partial and full blocks.
//  - Storage: 2 banks x 64 words. Block = 64 beats.
//  - Write: beat accepted when in_valid && in_ready. Written to wr bank at addr w_cnt (0..63), w_cnt++.
//    in_mode sampled at w_cnt==0 and stored per bank; changes of in_mode mid-block are ignored.
//    At w_cnt==0, in_mode==2'b00 forces in_ready=0 (no block start).
//    in_ready = !full[wr_bank] && !(w_cnt==0 && in_mode==2'b00) (combinational from flags).
//    Accepting beat 63: full[wr_bank]<=1, wr_bank toggles, w_cnt<=0.
//  - Read FSM: RD_IDLE -> RD_RUN when full[rd_bank]; RD_RUN -> RD_IDLE after fetching word 63
//    (that edge clears full[rd_bank] and toggles rd_bank); back-to-back RD_RUN if the other bank is full.
//  - Fetch happens when RD_RUN && (!out_valid || out_ready); loads d_out, out_mode, out_last, sets out_valid.
//    If no fetch and out_ready: out_valid<=0. Stall (out_valid && !out_ready): d_out/out_mode/out_last hold.
//  - Read address from r_cnt (0..63):
//      8x8 : addr = {r_cnt[2:0], r_cnt[5:3]}              (column-major of 8x8)
//      4x4 : addr = {r_cnt[5:4], r_cnt[1:0], r_cnt[3:2]}  (transpose inside each 16-word sub-block)
//  - Latency: last input beat accepted in cycle N -> out_valid=1 with first word in cycle N+2.
//  - Simultaneous: bank freed by read and write into the other bank in the same cycle are independent;
//    a freed bank raises in_ready the next cycle. Set and clear of the same flag cannot coincide.
//  - Both banks full: in_ready=0 until the read side fetches word 63 of the older block.
//  - Block order preserved; no word lost or duplicated under any out_ready pattern.
// STRUCTURE
//  - Shared package idct_pkg: MODE_IDLE=2'b00, MODE_4X4=2'b01, MODE_8X8=2'b10, BLK_WORDS=64, BLK_AW=6.
//  - One sub-module: transpose_addr_gen (combinational r_cnt+mode -> addr); banks are a local array.
// TESTING
//  1. 8x8 ramp 0..63, out_ready=1 -> d_out 0,8,16..56,1,9..63; out_last on 63; out_valid at N+2.
//  2. 4x4 ramp 0..63 -> 0,4,8,12,1,5,9,13,..,15, then 16,20,24,28,..; out_mode=2'b01 throughout.
//  3. 8x8 then 4x4 back-to-back, in_mode toggled mid-block -> in_ready never drops; tags per block start.
//  4. out_ready=0 -> in_ready drops after exactly 128 beats; d_out held stable while stalled.
//  5. Random out_ready (50%) over 10 blocks -> scoreboard exact match, no loss/duplication.
//  6. rst_n low at beat 30 -> outputs reset asynchronously; next block emits only fresh data.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared IDCT datapath definitions.
//   MODE_*     block size tags carried alongside the sample stream
//   BLK_WORDS  words per transpose block
//   BLK_AW     address width of one block
//   rd_state_e read-side sequencer states of the transpose buffer
package idct_pkg;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_4X4  = 2'b01;
    localparam logic [1:0] MODE_8X8  = 2'b10;

    localparam int BLK_WORDS = 64;
    localparam int BLK_AW    = 6;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_e;

endpackage

// File: rtl/transpose_rd_buf_if.sv
// Stream bundle of the read-side transpose buffer.
//   in_mode/in_valid/in_ready/d_in          raster-order input stream with block tag
//   out_valid/out_ready/d_out/out_mode/out_last  transposed output stream
// Handshake: a beat transfers on a rising edge where valid && ready. Once
// out_valid is high, d_out/out_mode/out_last stay stable until out_ready is
// seen high. in_ready may depend combinationally on in_mode (no block starts
// with an idle tag), so the source must hold in_mode stable while in_valid.
// slave  = the buffer, master = the environment driving and sinking it.
interface transpose_rd_buf_if #(
    parameter int WIDTH_X = 16
);
    logic [1:0]         in_mode;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH_X-1:0] d_in;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH_X-1:0] d_out;
    logic [1:0]         out_mode;
    logic               out_last;

    modport slave (
        input  in_mode, in_valid, d_in, out_ready,
        output in_ready, out_valid, d_out, out_mode, out_last
    );

    modport master (
        output in_mode, in_valid, d_in, out_ready,
        input  in_ready, out_valid, d_out, out_mode, out_last
    );
endinterface

// File: rtl/transpose_addr_gen.sv
// Read-address generator for the transpose buffer.
//   r_cnt  in   read word counter 0..63 (output order)
//   mode   in   block tag of the bank being read
//   addr   out  storage address (raster order) of that output word
module transpose_addr_gen
    import idct_pkg::*;
(
    input  logic [BLK_AW-1:0] r_cnt,
    input  logic [1:0]        mode,
    output logic [BLK_AW-1:0] addr
);
    always_comb begin
        // 8x8 (and tag 2'b11): swap row/column fields -> column-major walk.
        addr = {r_cnt[2:0], r_cnt[5:3]};
        // 4x4: keep the sub-block index, swap row/column inside the 16 words.
        if (mode == MODE_4X4) begin
            addr = {r_cnt[5:4], r_cnt[1:0], r_cnt[3:2]};
        end
    end
endmodule

// File: rtl/transpose_rd_buf.sv
// Ping-pong transpose buffer: raster-order writes, transposed-order reads.
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   bus           stream bundle (slave side), see transpose_rd_buf_if
//   dbg_rd_state  current read sequencer state
module transpose_rd_buf
    import idct_pkg::*;
#(
    parameter int WIDTH_X = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    transpose_rd_buf_if.slave   bus,
    output rd_state_e           dbg_rd_state
);
    localparam logic [BLK_AW-1:0] LAST_WORD = BLK_AW'(BLK_WORDS - 1);
    localparam logic [BLK_AW-1:0] ONE       = BLK_AW'(1);

    logic [WIDTH_X-1:0] mem [2][BLK_WORDS];
    logic [1:0]         bank_mode [2];
    logic [1:0]         full;
    logic               wr_bank;
    logic               rd_bank;
    logic [BLK_AW-1:0]  w_cnt;
    logic [BLK_AW-1:0]  r_cnt;
    logic [BLK_AW-1:0]  rd_addr;
    rd_state_e          state;
    rd_state_e          state_nxt;
    logic               start_blocked;
    logic               wr_acc;
    logic               wr_last;
    logic               fetch;
    logic               rd_last;

    // An idle tag can only hold off the start of a block; mid-block tags are ignored.
    assign start_blocked = (w_cnt == '0) && (bus.in_mode == MODE_IDLE);
    assign bus.in_ready  = !full[wr_bank] && !start_blocked;
    assign wr_acc        = bus.in_valid && bus.in_ready;
    assign wr_last       = (w_cnt == LAST_WORD);

    // Fetching straight off the full flag (not only in RD_RUN) lets word 0 be
    // fetched the cycle after the block completes.
    assign fetch   = ((state == RD_RUN) || full[rd_bank]) && (!bus.out_valid || bus.out_ready);
    assign rd_last = (r_cnt == LAST_WORD);

    assign dbg_rd_state = state;

    transpose_addr_gen u_addr_gen (
        .r_cnt (r_cnt),
        .mode  (bank_mode[rd_bank]),
        .addr  (rd_addr)
    );

    // Storage is not reset; validity is tracked by the full flags.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_bank][w_cnt] <= bus.d_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_cnt        <= '0;
            wr_bank      <= 1'b0;
            bank_mode[0] <= MODE_IDLE;
            bank_mode[1] <= MODE_IDLE;
        end else if (wr_acc) begin
            if (w_cnt == '0) begin
                bank_mode[wr_bank] <= bus.in_mode;
            end
            if (wr_last) begin
                w_cnt   <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                w_cnt <= w_cnt + ONE;
            end
        end
    end

    // Set needs !full[wr_bank], clear needs full[rd_bank]: never the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            if (wr_acc && wr_last) begin
                full[wr_bank] <= 1'b1;
            end
            if (fetch && rd_last) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = RD_RUN;
                end
            end
            RD_RUN: begin
                if (fetch && rd_last) begin
                    state_nxt = full[~rd_bank] ? RD_RUN : RD_IDLE;
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RD_IDLE;
            r_cnt         <= '0;
            rd_bank       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.d_out     <= '0;
            bus.out_mode  <= MODE_IDLE;
            bus.out_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fetch) begin
                bus.d_out     <= mem[rd_bank][rd_addr];
                bus.out_mode  <= bank_mode[rd_bank];
                bus.out_last  <= rd_last;
                bus.out_valid <= 1'b1;
                r_cnt         <= r_cnt + ONE;
                if (rd_last) begin
                    rd_bank <= ~rd_bank;
                end
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_transpose_rd_buf.sv
// Self-checking bench for transpose_rd_buf: directed blocks, scoreboard on the
// output stream, stall, back-to-back and mid-block reset scenarios.
module tb_transpose_rd_buf;
    import idct_pkg::*;

    logic      clk;
    logic      rst_n;
    rd_state_e dbg_rd_state;
    int        cyc;
    int        errors;
    int        checks;
    int        popped;
    int        sink_mode;   // 0 always ready, 1 never ready, 2 random
    logic [18:0] exp_q[$];  // {last, mode, data}

    transpose_rd_buf_if #(.WIDTH_X(16)) bus ();

    transpose_rd_buf #(.WIDTH_X(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .dbg_rd_state (dbg_rd_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Expected transposed word k of a ramp block starting at base.
    function automatic logic [15:0] exp_word(input logic [1:0] mode, input logic [15:0] base, input int k);
        int src;
        if (mode == MODE_4X4) src = (k / 16) * 16 + (k % 4) * 4 + (k % 16) / 4;
        else                  src = (k % 8) * 8 + k / 8;
        return base + 16'(src);
    endfunction

    task automatic push_block(input logic [1:0] mode, input logic [15:0] base);
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back({(k == 63), mode, exp_word(mode, base, k)});
        end
    endtask

    task automatic sink_loop();
        logic [18:0] got;
        logic [18:0] want;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (sink_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (bus.out_valid && bus.out_ready) begin
                got = {bus.out_last, bus.out_mode, bus.d_out};
                checks++;
                popped++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra_word: got %h, queue empty", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL sb_word: got {last,mode,data}=%h want %h", got, want);
                    end
                end
            end
        end
    endtask

    // Writes a 64-beat ramp; toggle flips in_mode after the first beat.
    task automatic write_block(input logic [1:0] mode, input logic [15:0] base, input bit toggle, output int stalls);
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.d_in     = base + 16'(i);
            bus.in_mode  = (toggle && i != 0) ? ~mode : mode;
            #1;
            while (!bus.in_ready && stalls < 2000) begin
                @(negedge clk);
                #1;
                stalls++;
            end
            if (!bus.in_ready) begin
                errors++;
                checks++;
                $display("FAIL write_timeout: beat %0d never accepted", i);
                break;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_mode  = MODE_IDLE;
        push_block(mode, base);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d words left, required 0", name, exp_q.size());
        end
        @(negedge clk);
        #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_valid: out_valid=%b required 0", name, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_mode  = MODE_IDLE;
        bus.d_in     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        checks += 6;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        if (bus.d_out !== 16'h0)    begin errors++; $display("FAIL rst_d_out: got %h want 0000", bus.d_out); end
        if (bus.out_mode !== 2'b00) begin errors++; $display("FAIL rst_out_mode: got %b want 00", bus.out_mode); end
        if (bus.out_last !== 1'b0)  begin errors++; $display("FAIL rst_out_last: got %b want 0", bus.out_last); end
        if (dbg_rd_state !== RD_IDLE) begin errors++; $display("FAIL rst_state: got %0d want RD_IDLE", dbg_rd_state); end
        if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready_idle_tag: got %b want 0", bus.in_ready); end
        rst_n = 1'b1;
        bus.in_mode = MODE_8X8;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_8x8: got %b want 1", bus.in_ready); end
        bus.in_mode = MODE_IDLE;
    endtask

    task automatic test_8x8();
        int stalls;
        sink_mode = 0;
        write_block(MODE_8X8, 16'd0, 1'b0, stalls);
        // Now in cycle N+1 after the last accepted beat.
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_n1: out_valid=%b want 0", bus.out_valid); end
        @(negedge clk);
        #1;
        checks += 2;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lat_n2: out_valid=%b want 1", bus.out_valid); end
        if (bus.d_out !== 16'd0)    begin errors++; $display("FAIL lat_first_word: got %0d want 0", bus.d_out); end
        @(negedge clk);
        #2;
        checks++;
        if (bus.d_out !== 16'd8) begin errors++; $display("FAIL 8x8_second_word: got %0d want 8", bus.d_out); end
        wait_drain("8x8");
    endtask

    task automatic test_4x4();
        int stalls;
        int p0;
        p0 = popped;
        write_block(MODE_4X4, 16'd0, 1'b0, stalls);
        wait_drain("4x4");
        checks++;
        if (popped - p0 != 64) begin errors++; $display("FAIL 4x4_count: got %0d want 64", popped - p0); end
    endtask

    task automatic test_back_to_back();
        int s0;
        int s1;
        write_block(MODE_8X8, 16'h1000, 1'b1, s0);
        write_block(MODE_4X4, 16'h2000, 1'b1, s1);
        checks += 2;
        if (s0 != 0) begin errors++; $display("FAIL b2b_stall_blk0: got %0d want 0", s0); end
        if (s1 != 0) begin errors++; $display("FAIL b2b_stall_blk1: got %0d want 0", s1); end
        wait_drain("b2b");
    endtask

    task automatic test_stall();
        int acc;
        logic [15:0] held;
        sink_mode = 1;
        acc = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_mode  = MODE_8X8;
            bus.d_in     = 16'h3000 + 16'(acc);
            #1;
            if (bus.in_ready) acc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks += 4;
        if (acc != 128)             begin errors++; $display("FAIL stall_accepted: got %0d want 128", acc); end
        if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", bus.out_valid); end
        if (bus.d_out !== 16'h3000) begin errors++; $display("FAIL stall_word: got %h want 3000", bus.d_out); end
        held = 16'h3000;
        repeat (10) @(negedge clk);
        #1;
        checks += 2;
        if (bus.d_out !== held)     begin errors++; $display("FAIL stall_hold: got %h want %h", bus.d_out, held); end
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid: got %b want 1", bus.out_valid); end
        push_block(MODE_8X8, 16'h3000);
        push_block(MODE_8X8, 16'h3040);
        sink_mode = 0;
        wait_drain("stall");
        bus.in_mode = MODE_8X8;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", bus.in_ready); end
        bus.in_mode = MODE_IDLE;
    endtask

    task automatic test_random_sink();
        int stalls;
        int p0;
        logic [1:0] m;
        p0 = popped;
        sink_mode = 2;
        for (int b = 0; b < 10; b++) begin
            m = (b == 4) ? 2'b11 : ((b % 2 == 1) ? MODE_4X4 : MODE_8X8);
            write_block(m, 16'($urandom_range(0, 60000)), 1'b0, stalls);
        end
        wait_drain("random");
        checks++;
        if (popped - p0 != 640) begin errors++; $display("FAIL random_count: got %0d want 640", popped - p0); end
        sink_mode = 0;
    endtask

    task automatic test_mid_reset();
        int stalls;
        sink_mode = 1;
        write_block(MODE_4X4, 16'h5000, 1'b0, stalls);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_mode  = MODE_8X8;
            bus.d_in     = 16'h6000 + 16'(i);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks += 6;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid: got %b want 0", bus.out_valid); end
        if (bus.d_out !== 16'h0)    begin errors++; $display("FAIL mrst_d_out: got %h want 0000", bus.d_out); end
        if (bus.out_mode !== 2'b00) begin errors++; $display("FAIL mrst_out_mode: got %b want 00", bus.out_mode); end
        if (bus.out_last !== 1'b0)  begin errors++; $display("FAIL mrst_out_last: got %b want 0", bus.out_last); end
        if (dbg_rd_state !== RD_IDLE) begin errors++; $display("FAIL mrst_state: got %0d want RD_IDLE", dbg_rd_state); end
        if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL mrst_in_ready: got %b want 1", bus.in_ready); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        sink_mode = 0;
        write_block(MODE_8X8, 16'h7000, 1'b0, stalls);
        wait_drain("mrst");
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        popped    = 0;
        sink_mode = 0;
        cyc       = 0;
        fork
            sink_loop();
        join_none
        test_reset();
        test_8x8();
        test_4x4();
        test_back_to_back();
        test_stall();
        test_random_sink();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
